mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath, replacing the single-cycle opcode decoder. It sequences one shared ALU and one unified memory across FETCH/DECODE/EXEC/MEM/WB steps. It drives all datapath enables and muxes as a Moore machine and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mips_ctrl_outdec.sv | 60 ++++++
 rtl/mips_multicycle_ctrl.sv | 109 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes, mux selects.
// Control-vector struct produced by the state decoder and consumed by the top.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EXEC = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // pc_write is unconditional; pc_cond is qualified by the ALU zero flag in the top.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_cond;
    logic       iord;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure combinational state -> control-vector decode (Moore outputs), zero latency.
// No flow control; strobe qualification by reset, zero flag and memory wait happens in the top.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:  ctrl_o.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD:  ctrl_o.iord = 1'b1;
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_OP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_cond   = 1'b1;
      end
      S_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_OP_IMM;
      end
      S_IMM_WB:  ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with saturating retire counter; lw 5, sw/R/imm 4, beq/j 3, illegal 2 cycles.
// With MIPS_MEM_WAIT_EN, FETCH/MEM_RD/MEM_WR stall until mem_ready; otherwise memory is always ready.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
`ifdef MIPS_MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic                ir_write,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [3:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_q, state_d;
  ctrl_t               ctrl;
  logic                mem_rdy;
  logic                legal;
  logic                terminal;
  logic                retire_evt;
  logic [RETIRE_W-1:0] retired_q;

`ifdef MIPS_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    state_d = S_FETCH;
    legal   = 1'b1;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI: state_d = S_IMM_EXEC;
          default: begin
            state_d = S_FETCH;
            legal   = 1'b0;
          end
        endcase
      end
      S_MEM_ADR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = mem_rdy ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_ALU_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  assign terminal   = state_q inside {S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_IMM_WB, S_JUMP};
  assign retire_evt = terminal && (state_d == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_evt && (retired_q != {RETIRE_W{1'b1}}))
        retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Strobes are gated by rst_n so the FETCH decode held during reset has no side effects.
  assign ir_write   = rst_n & ctrl.ir_write & mem_rdy;
  assign pc_en      = rst_n & ((ctrl.pc_write & ((state_q != S_FETCH) | mem_rdy)) |
                               (ctrl.pc_cond & zero));
  assign mem_write  = rst_n & ctrl.mem_write;
  assign reg_write  = rst_n & ctrl.reg_write;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state      = state_q;
  assign illegal    = rst_n & ~legal;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl; a second instance with a 2-bit counter covers saturation.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
`ifdef MIPS_MEM_WAIT_EN
  logic        mem_ready;
`endif

  logic        ir_write, pc_en, iord, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  logic        s_ir_write, s_pc_en, s_iord, s_mem_write, s_reg_dst, s_mem_to_reg, s_reg_write, s_alu_src_a;
  logic [1:0]  s_alu_src_b, s_alu_op, s_pc_src;
  logic [3:0]  s_state;
  logic        s_illegal;
  logic [1:0]  s_retired;

  logic [13:0] dvec, svec;
  int          n_checks = 0;
  int          n_errors = 0;
  int          ret_exp  = 0;

  assign dvec = {ir_write, pc_en, iord, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_src};
  assign svec = {s_ir_write, s_pc_en, s_iord, s_mem_write, s_reg_dst, s_mem_to_reg, s_reg_write,
                 s_alu_src_a, s_alu_src_b, s_alu_op, s_pc_src};

  mips_multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef MIPS_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(ir_write), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal(illegal), .retired(retired)
  );

  mips_multicycle_ctrl #(.RETIRE_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef MIPS_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(s_ir_write), .pc_en(s_pc_en), .iord(s_iord), .mem_write(s_mem_write),
    .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .pc_src(s_pc_src),
    .state(s_state), .illegal(s_illegal), .retired(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {ir_write,pc_en,iord,mem_write,reg_dst,mem_to_reg,reg_write,alu_src_a,srcb,aluop,pcsrc}.
  function automatic logic [13:0] exp_vec(input logic [3:0] st, input logic z, input logic rdy);
    case (st)
      4'd0:    return {rdy, rdy, 6'b000000, 2'b01, 2'b00, 2'b00};
      4'd1:    return {8'b0, 2'b11, 4'b0};
      4'd2:    return {7'b0, 1'b1, 2'b10, 4'b0};
      4'd3:    return {2'b0, 1'b1, 5'b0, 6'b0};
      4'd4:    return {5'b0, 2'b11, 1'b0, 6'b0};
      4'd5:    return {2'b0, 2'b11, 4'b0, 6'b0};
      4'd6:    return {7'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      4'd7:    return {4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
      4'd8:    return {1'b0, z, 5'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      4'd9:    return {7'b0, 1'b1, 2'b10, 2'b11, 2'b00};
      4'd10:   return {6'b0, 1'b1, 1'b0, 6'b0};
      4'd11:   return {1'b0, 1'b1, 6'b0, 2'b00, 2'b00, 2'b10};
      default: return 14'b0;
    endcase
  endfunction

  // path holds up to six expected state codes, one per nibble, first cycle in the top nibble.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z, input int n,
                           input logic [23:0] path, input logic ill, input logic ret);
    logic [3:0] es;
    for (int i = 0; i < n; i++) begin
      es = path[23-4*i -: 4];
      opcode = op;
      zero   = z;
      #1;
      check({tag, "_state"}, 32'(state), 32'(es));
      check({tag, "_ctl"}, 32'(dvec), 32'(exp_vec(es, z, 1'b1)));
      check({tag, "_illegal"}, 32'(illegal), 32'(ill && (es == 4'd1)));
      @(posedge clk); #1;
    end
    if (ret) ret_exp++;
    check({tag, "_retired"}, retired, 32'(ret_exp));
  endtask

`ifdef MIPS_MEM_WAIT_EN
  int   wst  [10] = '{0, 0, 0, 0, 1, 2, 5, 5, 5, 5};
  logic wrdy [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
`endif

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;
`ifdef MIPS_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'({ir_write, pc_en, mem_write, reg_write}), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("lw", 6'b100011, 1'b0, 5, 24'h012340, 1'b0, 1'b1);

    // Abandon a second lw in MEM_RD with an asynchronous reset.
    run_instr("lw_part", 6'b100011, 1'b0, 3, 24'h012000, 1'b0, 1'b0);
    check("pre_rst_state", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    ret_exp = 0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_strobes", 32'({ir_write, pc_en, mem_write, reg_write}), 32'd0);
    check("midrst_retired", retired, 32'd0);
    @(posedge clk); #1;
    check("midrst_hold_state", 32'(state), 32'd0);
    check("midrst_hold_strobes", 32'({ir_write, pc_en, mem_write, reg_write}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("rtype", 6'b000000, 1'b0, 4, 24'h016700, 1'b0, 1'b1);
    run_instr("sw",    6'b101011, 1'b0, 4, 24'h012500, 1'b0, 1'b1);
    run_instr("beq_t", 6'b000100, 1'b1, 3, 24'h018000, 1'b0, 1'b1);
    run_instr("beq_n", 6'b000100, 1'b0, 3, 24'h018000, 1'b0, 1'b1);
    run_instr("ill",   6'b111111, 1'b0, 2, 24'h010000, 1'b1, 1'b0);
    run_instr("j",     6'b000010, 1'b0, 3, 24'h01B000, 1'b0, 1'b1);
    run_instr("ori",   6'b001101, 1'b0, 4, 24'h019A00, 1'b0, 1'b1);

`ifdef MIPS_MEM_WAIT_EN
    for (int i = 0; i < 10; i++) begin
      opcode    = 6'b101011;
      zero      = 1'b0;
      mem_ready = wrdy[i];
      #1;
      check("wait_state", 32'(state), 32'(wst[i]));
      check("wait_ctl", 32'(dvec), 32'(exp_vec(4'(wst[i]), 1'b0, wrdy[i])));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    ret_exp++;
    check("wait_retired", retired, 32'(ret_exp));
    check("wait_state_end", 32'(state), 32'd0);
`endif

    #1;
    check("sat_retired", 32'(s_retired), 32'((ret_exp > 3) ? 3 : ret_exp));
    check("sat_ctl", 32'({svec, s_state, s_illegal}), 32'({exp_vec(4'd0, zero, 1'b1), 4'd0, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
